// File: rtl/cnt_tick_gen.sv
// Multi-channel programmable tick generator: each channel divides clk by its own period.
// Optional one-shot mode (oneshot/done ports) is enabled by defining CNT_TICK_ONESHOT_EN.
module cnt_tick_gen #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         en,
    input  logic [NCH-1:0]         clr,
    input  logic [NCH*WIDTH-1:0]   period,
    output logic [NCH-1:0]         hit,
    output logic [NCH*WIDTH-1:0]   cnt_o
`ifdef CNT_TICK_ONESHOT_EN
    ,
    input  logic [NCH-1:0]         oneshot,
    output logic [NCH-1:0]         done
`endif
);

    logic [WIDTH-1:0] cnt   [NCH];
    logic [WIDTH-1:0] per_q [NCH];
    logic [WIDTH-1:0] eff   [NCH];
    logic [NCH-1:0]   term;

    // At the start of a sequence the live period is used, so a new P applies immediately.
    always_comb begin
        term  = '0;
        cnt_o = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            eff[k] = (cnt[k] == '0) ? period[k*WIDTH +: WIDTH] : per_q[k];
            term[k] = (eff[k] <= WIDTH'(1)) || (cnt[k] == eff[k] - WIDTH'(1));
            cnt_o[k*WIDTH +: WIDTH] = cnt[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit <= '0;
`ifdef CNT_TICK_ONESHOT_EN
            done <= '0;
`endif
            for (int unsigned k = 0; k < NCH; k++) begin
                cnt[k]   <= '0;
                per_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (cnt[k] == '0 && en[k])
                    per_q[k] <= period[k*WIDTH +: WIDTH];

                if (clr[k]) begin
                    cnt[k] <= '0;
                    hit[k] <= 1'b0;
`ifdef CNT_TICK_ONESHOT_EN
                    done[k] <= 1'b0;
                end else if (done[k]) begin
                    // Finished one-shot parks at zero until a clear or a pause re-arms it.
                    hit[k] <= 1'b0;
                    if (!en[k])
                        done[k] <= 1'b0;
`endif
                end else if (en[k] && term[k]) begin
                    cnt[k] <= '0;
                    hit[k] <= 1'b1;
`ifdef CNT_TICK_ONESHOT_EN
                    done[k] <= oneshot[k];
`endif
                end else if (en[k]) begin
                    cnt[k] <= cnt[k] + WIDTH'(1);
                    hit[k] <= 1'b0;
                end else begin
                    hit[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cnt_tick_gen.sv
// Scoreboard bench for cnt_tick_gen: driver queues expected hit/count per step, monitor checks after each edge.
module tb_cnt_tick_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic [3:0]  clr;
    logic [31:0] period;
    logic [3:0]  hit;
    logic [31:0] cnt_o;
`ifdef CNT_TICK_ONESHOT_EN
    logic [3:0]  oneshot;
    logic [3:0]  done;
`endif

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        int         tid;
        int         ch;
        logic       hit;
        logic [7:0] cnt;
        logic       done;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    cnt_tick_gen #(.WIDTH(8), .NCH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .period  (period),
        .hit     (hit),
        .cnt_o   (cnt_o)
`ifdef CNT_TICK_ONESHOT_EN
        ,
        .oneshot (oneshot),
        .done    (done)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input int tid, input int ch, input logic e_in, input logic c_in,
                        input logic [7:0] p, input logic eh, input logic [7:0] ec, input logic ed);
        exp_t x;
        @(negedge clk);
        en = '0;
        clr = '0;
        en[ch] = e_in;
        clr[ch] = c_in;
        period[ch*8 +: 8] = p;
        x.tid = tid; x.ch = ch; x.hit = eh; x.cnt = ec; x.done = ed;
        sb.push_back(x);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            nvec++;
            if (hit[e.ch] !== e.hit || cnt_o[e.ch*8 +: 8] !== e.cnt) begin
                nfail++;
                $display("FAIL t%0d ch%0d @%0t: got hit=%0b cnt=%0d, required hit=%0b cnt=%0d",
                         e.tid, e.ch, $time, hit[e.ch], cnt_o[e.ch*8 +: 8], e.hit, e.cnt);
            end
`ifdef CNT_TICK_ONESHOT_EN
            if (done[e.ch] !== e.done) begin
                nfail++;
                $display("FAIL t%0d done ch%0d @%0t: got %0b, required %0b",
                         e.tid, e.ch, $time, done[e.ch], e.done);
            end
`endif
        end
    end

    int c3[10] = '{5, 6, 7, 0, 1, 2, 0, 1, 2, 0};
    int h3[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};

    initial begin
        rst = 1'b1; en = '0; clr = '0; period = '0;
`ifdef CNT_TICK_ONESHOT_EN
        oneshot = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (hit !== 4'h0 || cnt_o !== 32'h0) begin
            nfail++;
            $display("FAIL reset: got hit=%h cnt_o=%h, required 0/0", hit, cnt_o);
        end
`ifdef CNT_TICK_ONESHOT_EN
        nvec++;
        if (done !== 4'h0) begin
            nfail++;
            $display("FAIL reset done: got %h, required 0", done);
        end
`endif
        @(negedge clk);
        rst = 1'b0;

        // ch0, P=5: hits on every 5th enabled edge
        for (int i = 1; i <= 20; i++)
            step(1, 0, 1'b1, 1'b0, 8'd5, (i % 5) == 0, 8'(i % 5), 1'b0);

        // ch1, P=0 then P=1: hit after every enabled edge, count stuck at 0
        for (int i = 0; i < 4; i++) step(2, 1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(2, 1, 1'b1, 1'b0, 8'd1, 1'b1, 8'd0, 1'b0);

        // ch2, P=8 then period changed to 3 at count 4: first wrap at 8, then every 3
        for (int i = 1; i <= 4; i++) step(3, 2, 1'b1, 1'b0, 8'd8, 1'b0, 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) step(3, 2, 1'b1, 1'b0, 8'd3, 1'(h3[i]), 8'(c3[i]), 1'b0);

        // ch3, P=6 with a 4-cycle pause at count 2, then clear tests
        step(4, 3, 1'b1, 1'b0, 8'd6, 1'b0, 8'd1, 1'b0);
        step(4, 3, 1'b1, 1'b0, 8'd6, 1'b0, 8'd2, 1'b0);
        for (int i = 0; i < 4; i++) step(4, 3, 1'b0, 1'b0, 8'd6, 1'b0, 8'd2, 1'b0);
        step(4, 3, 1'b1, 1'b0, 8'd6, 1'b0, 8'd3, 1'b0);
        step(4, 3, 1'b1, 1'b0, 8'd6, 1'b0, 8'd4, 1'b0);
        step(4, 3, 1'b1, 1'b0, 8'd6, 1'b0, 8'd5, 1'b0);
        step(4, 3, 1'b1, 1'b0, 8'd6, 1'b1, 8'd0, 1'b0);
        step(4, 3, 1'b1, 1'b0, 8'd6, 1'b0, 8'd1, 1'b0);
        step(4, 3, 1'b1, 1'b0, 8'd6, 1'b0, 8'd2, 1'b0);
        step(4, 3, 1'b1, 1'b1, 8'd2, 1'b0, 8'd0, 1'b0);
        step(4, 3, 1'b1, 1'b0, 8'd2, 1'b0, 8'd1, 1'b0);
        step(4, 3, 1'b1, 1'b1, 8'd2, 1'b0, 8'd0, 1'b0);
        step(4, 3, 1'b1, 1'b0, 8'd2, 1'b0, 8'd1, 1'b0);
        step(4, 3, 1'b1, 1'b0, 8'd2, 1'b1, 8'd0, 1'b0);

        // async reset between edges with ch2 mid-count and ch0 hit high
        for (int i = 1; i <= 3; i++) step(5, 2, 1'b1, 1'b0, 8'd8, 1'b0, 8'(i), 1'b0);
        for (int i = 1; i <= 5; i++) step(5, 0, 1'b1, 1'b0, 8'd5, i == 5, 8'(i % 5), 1'b0);
        #3;
        rst = 1'b1;
        #1;
        nvec++;
        if (hit !== 4'h0 || cnt_o !== 32'h0) begin
            nfail++;
            $display("FAIL async_rst: got hit=%h cnt_o=%h, required 0/0", hit, cnt_o);
        end
`ifdef CNT_TICK_ONESHOT_EN
        nvec++;
        if (done !== 4'h0) begin
            nfail++;
            $display("FAIL async_rst done: got %h, required 0", done);
        end
`endif
        @(negedge clk);
        rst = 1'b0;

`ifdef CNT_TICK_ONESHOT_EN
        // one-shot ch0, P=4: single hit, done holds, clear re-arms, pause clears done
        oneshot = 4'b0001;
        for (int i = 1; i <= 3; i++) step(6, 0, 1'b1, 1'b0, 8'd4, 1'b0, 8'(i), 1'b0);
        step(6, 0, 1'b1, 1'b0, 8'd4, 1'b1, 8'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(6, 0, 1'b1, 1'b0, 8'd4, 1'b0, 8'd0, 1'b1);
        step(6, 0, 1'b1, 1'b1, 8'd4, 1'b0, 8'd0, 1'b0);
        for (int i = 1; i <= 3; i++) step(6, 0, 1'b1, 1'b0, 8'd4, 1'b0, 8'(i), 1'b0);
        step(6, 0, 1'b1, 1'b0, 8'd4, 1'b1, 8'd0, 1'b1);
        step(6, 0, 1'b0, 1'b0, 8'd4, 1'b0, 8'd0, 1'b0);
        step(6, 0, 1'b1, 1'b0, 8'd4, 1'b0, 8'd1, 1'b0);
        oneshot = '0;
`endif

        @(negedge clk);
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL drain: got %0d pending, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/cnt_tick_gen.md
# cnt_tick_gen

Multi-channel programmable tick generator: a parametrised successor to the fixed divide-by-5 hit counter. Each of NCH independent channels divides `clk` by a runtime-programmable period P and emits a registered one-cycle `hit` pulse once per period. Channels support pause (enable), synchronous clear and glitch-free period changes. The block sits next to the datapath blocks and supplies their sample, strobe and timeout ticks.

## Interface
- `WIDTH`, default 8: counter and period width per channel; maximum P = 2^WIDTH-1.
- `NCH`, default 4: number of independent channels.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  NCH  per-channel count enable; low = pause, count held.
- `clr`  in  NCH  per-channel synchronous clear; priority over `en`.
- `period`  in  NCH*WIDTH  per-channel divisor P; channel k uses bits [k*WIDTH +: WIDTH].
- `hit`  out  NCH  registered one-cycle tick per channel.
- `cnt_o`  out  NCH*WIDTH  current count per channel, same packing as `period`.
- `oneshot`  in  NCH  one-shot mode select; present only with CNT_TICK_ONESHOT_EN.
- `done`  out  NCH  one-shot completed; present only with CNT_TICK_ONESHOT_EN.

## Operation
- Per channel k: count register `cnt`, held period register `per_q`, and registered `hit`.
- Effective period `eff`:
  - when `cnt`==0, `eff` = live `period` input;
  - otherwise `eff` = `per_q`.
  - `per_q` loads `period` on every cycle with `cnt`==0 and `en`=1, so P is sampled once at the start of each count sequence. Changes to `period` mid-sequence take effect at the next wrap.
- Terminal condition: (`eff` <= 1) or (`cnt` == `eff`-1). Compare at WIDTH bits; `eff`-1 never underflows because `eff` <= 1 is handled separately.
- Next-state priority:
  - `clr`: `cnt`<=0, `hit`<=0.
  - else `en` & terminal: `cnt`<=0, `hit`<=1.
  - else `en`: `cnt`<=`cnt`+1, `hit`<=0.
  - else: `cnt` held, `hit`<=0.
- Sequence with P=5 and `en` high: `cnt_o` runs 0,1,2,3,4,0,... and `hit`=1 exactly in the cycles where `cnt_o` has just wrapped to 0.
- P=0 or P=1: `hit` is high every cycle following an enabled cycle; `cnt_o` stays 0.
- Invariant: `cnt` < max(`per_q`,1) at all times; no wrap-around past 2^WIDTH-1.
- Channels are fully independent. There is no cross-channel interaction or shared state.

## Timing
- Reset values, asynchronous on `rst`=1: `cnt`=0, `per_q`=0, `hit`=0, `done`=0 for all channels.
- First edge after reset release with `en`=1 and P=5: `cnt_o`=1. `hit` first rises after the 5th enabled edge.
- Latency: `hit` is registered, asserted the cycle after the terminal count was sampled with `en`=1.
- `en` low for N cycles delays the next hit by exactly N cycles; `cnt_o` is frozen during the pause.
- `clr` and `en` high in the same cycle: the clear wins; the count sequence restarts and a new P is sampled on the next cycle.
- `rst` asserted mid-sequence: all outputs return to reset values immediately, without waiting for a clock edge.

## Configuration
- CNT_TICK_ONESHOT_EN defined:
  - `oneshot` and `done` ports exist.
  - A channel with `oneshot[k]`=1 sets `done[k]` on the same edge that raises its `hit`.
  - While `done[k]`=1, `cnt` is held at 0 and no further hits occur.
  - `done[k]` clears on `clr[k]`=1 or `en[k]`=0; counting resumes on the next enabled cycle.
- Macro undefined: ports absent, all channels always periodic, no done state.

## Test plan
- Reset, then `en[0]`=1, P=5 for 20 cycles: `hit[0]` high at enabled edges 5, 10, 15, 20; `cnt_o` runs 0..4 repeatedly.
- P=0 and P=1 on channel 1 with `en`=1: `hit[1]` high every cycle from the 2nd cycle on; `cnt_o[1]` stays 0.
- Channel 2 P=8, change `period` to 3 at `cnt_o`=4: the current sequence completes at 8; following hits occur every 3 cycles.
- Drop `en[3]` for 4 cycles at `cnt_o`=2 with P=6: the hit is delayed by exactly 4 cycles and `cnt_o` holds 2 during the pause. Assert `clr` together with `en`: `cnt_o` goes to 0 and there is no hit in that cycle.
- Assert `rst` asynchronously mid-count, between edges: `hit`, `cnt_o` and `done` go to 0 before the next edge.
- With CNT_TICK_ONESHOT_EN, `oneshot[0]`=1, P=4: exactly one hit at edge 4 and `done[0]`=1 thereafter. After `clr[0]`, a new hit arrives 4 enabled cycles later.
